// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction field layout, NOP encoding and
// the fetch FSM state type.
package mips_pkg;

  // Field widths
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;

  // Field LSB positions within the 32-bit instruction word
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_LSB = 0;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // StFetch: request outstanding; StHold: word parked in skid buffer, no request;
  // StDrain: wrong-path request outstanding, its word will be dropped.
  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries valid, raw instruction and PC+4.
// Priority is flush > load > bubble > hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;

  // Pipeline register update; a bubble only drops valid and leaves the payload
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_NOP;
      pc_plus4_q <= 32'h0;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_NOP;
      pc_plus4_q <= 32'h0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
    end else if (bubble_i) begin
      valid_q    <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch front end: PC, req/ack fetch FSM with one-entry skid
// buffer, and the IF/ID register with decode field slices.
module fetch_decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                id_valid,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc_plus4,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [REG_W-1:0]    id_rs,
  output logic [REG_W-1:0]    id_rt,
  output logic [REG_W-1:0]    id_rd,
  output logic [SHAMT_W-1:0]  id_shamt,
  output logic [FUNCT_W-1:0]  id_funct,
  output logic [IMM_W-1:0]    id_imm16,
  output logic [TARGET_W-1:0] id_target26
);

  localparam logic [31:0] PcStep = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  skid_q, skid_d;

  logic [31:0]  redirect_tgt;
  logic [31:0]  pc_inc;
  logic         ifid_load;
  logic         ifid_flush;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc       = pc_q + PcStep;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (redirect_valid) begin
          state_d = imem_ack ? StFetch : StDrain;
        end else if (imem_ack && stall) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (redirect_valid || !stall) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Output logic; request is suppressed while reset is held
  always_comb begin
    imem_req  = (state_q != StHold) && !reset;
    imem_addr = req_addr_q;
  end

  // PC, request address, skid buffer and IF/ID control
  always_comb begin
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    skid_d      = skid_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rdata;
    ifid_flush  = redirect_valid;
    unique case (state_q)
      StFetch: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // A word landing with the redirect is wrong-path; restart at target now
          if (imem_ack) begin
            req_addr_d = redirect_tgt;
          end
        end else if (imem_ack) begin
          if (!stall) begin
            ifid_load  = 1'b1;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
          end else begin
            skid_d = imem_rdata;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_q;
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
        end
      end
      StDrain: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
        // Stale word is dropped; the next request goes to the latest target
        if (imem_ack) begin
          req_addr_d = pc_d;
        end
      end
      default: ;
    endcase
  end

  // PC, request address and skid buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      skid_q     <= INSTR_NOP;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      skid_q     <= skid_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .bubble_i   (ifid_bubble),
    .instr_i    (ifid_instr),
    .pc_plus4_i (req_addr_q + PcStep),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_plus4_o (id_pc_plus4)
  );

  assign id_opcode   = id_instr[OPCODE_LSB +: OPCODE_W];
  assign id_rs       = id_instr[RS_LSB +: REG_W];
  assign id_rt       = id_instr[RT_LSB +: REG_W];
  assign id_rd       = id_instr[RD_LSB +: REG_W];
  assign id_shamt    = id_instr[SHAMT_LSB +: SHAMT_W];
  assign id_funct    = id_instr[FUNCT_LSB +: FUNCT_W];
  assign id_imm16    = id_instr[IMM_LSB +: IMM_W];
  assign id_target26 = id_instr[TARGET_LSB +: TARGET_W];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios followed by randomized
// stall/redirect/latency traffic, all checked against a transaction-level model.
module tb_fetch_decode_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [25:0] id_target26;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_decode_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4),
    .id_opcode      (id_opcode),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_shamt       (id_shamt),
    .id_funct       (id_funct),
    .id_imm16       (id_imm16),
    .id_target26    (id_target26)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: next PC to fetch, address of the outstanding request,
  // whether that request is wrong-path, an optional parked word, and IF/ID.
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  logic        m_stale;
  logic        m_parked;
  logic [31:0] m_parked_word;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  function automatic logic m_req();
    return !m_parked;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    m_pc          = 32'h0;
    m_req_addr    = 32'h0;
    m_stale       = 1'b0;
    m_parked      = 1'b0;
    m_parked_word = 32'h0;
    m_valid       = 1'b0;
    m_instr       = 32'h0;
    m_pc4         = 32'h0;
  endtask

  task automatic model_cycle(input logic st, input logic rv, input logic [31:0] rp,
                             input logic ak, input logic [31:0] rd);
    logic [31:0] tgt;
    tgt = {rp[31:2], 2'b00};
    if (m_parked) begin
      if (rv) begin
        m_parked   = 1'b0;
        m_pc       = tgt;
        m_req_addr = tgt;
      end else if (!st) begin
        m_valid    = 1'b1;
        m_instr    = m_parked_word;
        m_pc4      = m_req_addr + 32'd4;
        m_parked   = 1'b0;
        m_pc       = m_req_addr + 32'd4;
        m_req_addr = m_pc;
      end
    end else if (m_stale) begin
      if (rv) m_pc = tgt;
      else if (!st) m_valid = 1'b0;
      if (ak) begin
        m_req_addr = m_pc;
        m_stale    = 1'b0;
      end
    end else begin
      if (rv) begin
        m_pc = tgt;
        if (ak) m_req_addr = tgt;
        else m_stale = 1'b1;
      end else if (ak && !st) begin
        m_valid    = 1'b1;
        m_instr    = rd;
        m_pc4      = m_req_addr + 32'd4;
        m_pc       = m_req_addr + 32'd4;
        m_req_addr = m_pc;
      end else if (ak) begin
        m_parked      = 1'b1;
        m_parked_word = rd;
      end else if (!st) begin
        m_valid = 1'b0;
      end
    end
    if (rv) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", imem_addr, m_req_addr);
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    if (m_valid) begin
      chk("id_instr", id_instr, m_instr);
      chk("id_pc_plus4", id_pc_plus4, m_pc4);
      chk("id_opcode", 32'(id_opcode), 32'(m_instr[31:26]));
      chk("id_rs", 32'(id_rs), 32'(m_instr[25:21]));
      chk("id_rt", 32'(id_rt), 32'(m_instr[20:16]));
      chk("id_rd", 32'(id_rd), 32'(m_instr[15:11]));
      chk("id_shamt", 32'(id_shamt), 32'(m_instr[10:6]));
      chk("id_funct", 32'(id_funct), 32'(m_instr[5:0]));
      chk("id_imm16", 32'(id_imm16), 32'(m_instr[15:0]));
      chk("id_target26", 32'(id_target26), 32'(m_instr[25:0]));
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input logic st, input logic rv, input logic [31:0] rp,
                      input logic ak, input logic [31:0] rd);
    logic ak_eff;
    ak_eff         = ak && m_req();
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ack       = ak_eff;
    imem_rdata     = rd;
    model_cycle(st, rv, rp, ak_eff, rd);
    @(posedge clk);
    #1;
    check_all();
  endtask

  localparam logic [31:0] AddiWord = 32'h2008_0037;
  localparam logic [31:0] LuiWord  = 32'h3C01_8000;

  initial begin
    int wait_left;
    logic st, rv, ak;
    logic [31:0] rp;

    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    model_reset();

    // Reset values
    @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);
    chk("rst_target", 32'(id_target26), 32'h0);
    reset = 1'b0;
    #1;
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // Zero-wait fetch: addresses 0, 4, 8
    step(1'b0, 1'b0, 32'h0, 1'b1, AddiWord);
    chk("addi_addr4", imem_addr, 32'h4);
    chk("addi_valid", 32'(id_valid), 32'h1);
    chk("addi_imm", 32'(id_imm16), 32'h0037);
    chk("addi_rt", 32'(id_rt), 32'd8);
    chk("addi_op", 32'(id_opcode), 32'h08);
    chk("addi_pc4", id_pc_plus4, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1, LuiWord);
    chk("lui_addr8", imem_addr, 32'h8);
    chk("lui_imm", 32'(id_imm16), 32'h8000);
    chk("lui_sext", {{16{id_imm16[15]}}, id_imm16}, 32'hFFFF_8000);

    // Stall while the addr-8 word arrives: park it, hold IF/ID
    step(1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'h8));
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_pc4", id_pc_plus4, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold_pc4_b", id_pc_plus4, 32'h8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rel_pc4", id_pc_plus4, 32'hC);
    chk("rel_addr12", imem_addr, 32'hC);

    // Redirect with stall: flush wins, target aligned
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1, mem_word(32'hC));
    chk("flush_valid", 32'(id_valid), 32'h0);
    chk("flush_nop", id_instr, 32'h0);
    chk("redir_addr", imem_addr, 32'h100);

    // Get to addr 16, then redirect while its ack is delayed
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h100));
    step(1'b0, 1'b1, 32'h0000_000C, 1'b1, mem_word(32'h104));
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'hC));
    chk("at16", imem_addr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_req", 32'(imem_req), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("drain_drop", 32'(id_valid), 32'h0);
    chk("drain_next", imem_addr, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'h200));
    chk("post_drain", id_instr, mem_word(32'h200));

    // Wrap-around at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    chk("wrap_req", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC));
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", id_pc_plus4, 32'h0);

    // Reset asserted during HOLD
    step(1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'h0));
    chk("hold2_req", 32'(imem_req), 32'h0);
    reset = 1'b1;
    stall = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("midrst_valid", 32'(id_valid), 32'h0);
    chk("midrst_req", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_req1", 32'(imem_req), 32'h1);

    // Randomized traffic with 0..2 cycle memory latency
    wait_left = 0;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rp = $urandom;
      ak = (wait_left == 0);
      if (m_req()) begin
        if (wait_left == 0) wait_left = $urandom_range(0, 2);
        else wait_left--;
      end
      step(st, rv, rp, ak, mem_word(m_req_addr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
